ili_cmd_seq: RTL and testbench



---
 rtl/ili_cmd_seq.sv | 183 ++++++++++++++++++
 tb/tb_ili_cmd_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ili_cmd_seq.sv
// rtl/ili_cmd_seq.sv - ILI9341 init/command table sequencer
//
// Walks a synchronous command ROM on a start pulse and hands each CMD/DATA
// byte to the SPI byte sender over a valid/ready handshake, honouring
// millisecond DELAY entries and stopping at END.
//
// Optional feature macro: ILI_SEQ_LOOP_EN
//   defined     : END restarts fetching at LOOP_ADDR, o_done pulses per pass
//   not defined : END finishes in DONE, LOOP_ADDR only range-checked
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_start       start pulse, honoured only in IDLE/DONE
//   o_rom_addr    ROM read address
//   i_rom_data    ROM word {type[1:0], payload[DW-1:0]}, 1-cycle latency
//   o_tx_valid    byte offered to SPI sender
//   o_tx_data     byte to send
//   o_tx_dc       0 = command byte, 1 = data byte
//   i_tx_ready    SPI sender accepts byte
//   o_busy        high outside IDLE/DONE
//   o_done        high in DONE (1-cycle pulse per END in loop mode)
//   o_overrun     sticky, table ran past last address without END

module ili_cmd_seq #(
  parameter int DW        = 8,
  parameter int ROM_AW    = 6,
  parameter int CLK_KHZ   = 100000,
  parameter int LOOP_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [DW+1:0]     i_rom_data,
  output logic              o_tx_valid,
  output logic [DW-1:0]     o_tx_data,
  output logic              o_tx_dc,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);

  localparam int PW = $clog2(CLK_KHZ + 1);

  localparam logic [1:0]        T_CMD    = 2'b00;
  localparam logic [1:0]        T_DATA   = 2'b01;
  localparam logic [1:0]        T_DELAY  = 2'b10;
  localparam logic [ROM_AW-1:0] ADDR_MAX = '1;
  localparam logic [ROM_AW-1:0] ADDR_ONE = ROM_AW'(1);
  localparam logic [DW-1:0]     MS_ONE   = DW'(1);
  localparam logic [PW-1:0]     PRE_ONE  = PW'(1);
  localparam logic [PW-1:0]     PRE_LAST = PW'(CLK_KHZ - 1);

  if (LOOP_ADDR < 0 || LOOP_ADDR >= (1 << ROM_AW)) begin : g_loop_addr_check
    $error("LOOP_ADDR out of ROM range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [ROM_AW-1:0] addr, addr_n;
  logic [1:0]        ent_type, ent_type_n;
  logic [DW-1:0]     ent_data, ent_data_n;
  logic [DW-1:0]     ms_cnt, ms_cnt_n;
  logic [PW-1:0]     pre_cnt, pre_cnt_n;
  logic              overrun, overrun_n;
  logic              done, done_n;
  logic              advance;
  logic              loop_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      addr     <= '0;
      ent_type <= '0;
      ent_data <= '0;
      ms_cnt   <= '0;
      pre_cnt  <= '0;
      overrun  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      ent_type <= ent_type_n;
      ent_data <= ent_data_n;
      ms_cnt   <= ms_cnt_n;
      pre_cnt  <= pre_cnt_n;
      overrun  <= overrun_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    addr_n     = addr;
    ent_type_n = ent_type;
    ent_data_n = ent_data;
    ms_cnt_n   = ms_cnt;
    pre_cnt_n  = pre_cnt;
    overrun_n  = overrun;
    advance    = 1'b0;
    loop_end   = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_n   = S_FETCH;
          addr_n    = '0;
          overrun_n = 1'b0;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        // The entry is latched here so SEND drives a payload that cannot
        // change while the sender is stalling.
        ent_type_n = i_rom_data[DW+1:DW];
        ent_data_n = i_rom_data[DW-1:0];
        case (i_rom_data[DW+1:DW])
          T_CMD, T_DATA: state_n = S_SEND;
          T_DELAY: begin
            if (i_rom_data[DW-1:0] != '0) begin
              state_n   = S_WAIT;
              ms_cnt_n  = i_rom_data[DW-1:0];
              pre_cnt_n = '0;
            end else begin
              advance = 1'b1;
            end
          end
          default: begin
`ifdef ILI_SEQ_LOOP_EN
            state_n  = S_FETCH;
            addr_n   = ROM_AW'(LOOP_ADDR);
            loop_end = 1'b1;
`else
            state_n  = S_DONE;
`endif
          end
        endcase
      end
      S_SEND: begin
        if (i_tx_ready) advance = 1'b1;
      end
      S_WAIT: begin
        // ms_cnt reaches 1 on the last millisecond, so WAIT lasts exactly
        // payload*CLK_KHZ cycles.
        if (pre_cnt == PRE_LAST) begin
          pre_cnt_n = '0;
          if (ms_cnt == MS_ONE) advance = 1'b1;
          else                  ms_cnt_n = ms_cnt - MS_ONE;
        end else begin
          pre_cnt_n = pre_cnt + PRE_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (advance) begin
      if (addr == ADDR_MAX) begin
        overrun_n = 1'b1;
        state_n   = S_DONE;
      end else begin
        addr_n  = addr + ADDR_ONE;
        state_n = S_FETCH;
      end
    end

    done_n = (state_n == S_DONE) || loop_end;
  end

  // Valid is decoded from the asynchronously reset state so it drops the
  // instant rst is asserted.
  assign o_tx_valid = (state == S_SEND);
  assign o_tx_data  = ent_data;
  assign o_tx_dc    = (ent_type == T_DATA);
  assign o_rom_addr = addr;
  assign o_busy     = (state != S_IDLE) && (state != S_DONE);
  assign o_done     = done;
  assign o_overrun  = overrun;

endmodule

// File: tb/tb_ili_cmd_seq.sv
// tb/tb_ili_cmd_seq.sv - self-checking bench for ili_cmd_seq
module tb_ili_cmd_seq;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int KHZ = 10;
  localparam int LOOPA = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_start = 1'b0;
  logic i_tx_ready = 1'b0;
  logic [AW-1:0] o_rom_addr;
  logic [DW+1:0] rom_data;
  logic o_tx_valid, o_tx_dc, o_busy, o_done, o_overrun;
  logic [DW-1:0] o_tx_data;

  ili_cmd_seq #(.DW(DW), .ROM_AW(AW), .CLK_KHZ(KHZ), .LOOP_ADDR(LOOPA)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_rom_addr(o_rom_addr),
    .i_rom_data(rom_data), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
    .o_tx_dc(o_tx_dc), .i_tx_ready(i_tx_ready), .o_busy(o_busy),
    .o_done(o_done), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  logic [DW+1:0] rom [4];
  always @(posedge clk) rom_data <= rom[o_rom_addr];

  int checks = 0;
  int failures = 0;
  logic [DW:0] got[$];
  logic [DW:0] exp_q[$];
  bit exp_ovr;
  int exp_cyc;
  bit rnd_ready = 1'b0;
  logic prev_hold = 1'b0;
  logic [DW:0] prev_byte = '0;

  // Transfer monitor plus the "valid never drops without a transfer" rule.
  always @(negedge clk) begin
    if (rst && prev_hold) begin
      checks++;
      if (!(o_tx_valid && {o_tx_dc, o_tx_data} == prev_byte)) begin
        failures++;
        $display("FAIL hold: valid=%0b byte=%h required valid=1 byte=%h",
                 o_tx_valid, {o_tx_dc, o_tx_data}, prev_byte);
      end
    end
    if (o_tx_valid && i_tx_ready) got.push_back({o_tx_dc, o_tx_data});
    prev_hold = rst && o_tx_valid && !i_tx_ready;
    prev_byte = {o_tx_dc, o_tx_data};
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) i_tx_ready = 1'($urandom_range(0, 1));
  end

  typedef struct {
    logic [39:0] w;
    int n;
    logic [35:0] b;
    bit ovr;
    int cyc;
  } vec_t;

  function automatic logic [9:0] W(input logic [1:0] t, input logic [7:0] d);
    return {t, d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Reference: walk the table by its rules; ready assumed always high for cycles.
  task automatic model();
    exp_q.delete();
    exp_ovr = 1'b1;
    exp_cyc = 1;
    for (int a = 0; a < 4; a++) begin
      logic [1:0] t;
      int d;
      t = rom[a][9:8];
      d = int'(rom[a][7:0]);
      if (t == 2'd3) begin
        exp_cyc += 2;
        exp_ovr = 1'b0;
        break;
      end else if (t == 2'd2) begin
        exp_cyc += 2 + d * KHZ;
      end else begin
        exp_q.push_back({t[0], rom[a][7:0]});
        exp_cyc += 3;
      end
    end
  endtask

  task automatic run(input int maxcyc, output int cyc);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    cyc = 1;
    while (!o_done && cyc < maxcyc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!o_done) begin
      failures++;
      checks++;
      $display("FAIL timeout: done=0 after %0d cycles required done=1", cyc);
    end
  endtask

  task automatic cmp_bytes(input string nm);
    chk({nm, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(nm, got[i], exp_q[i]);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!o_tx_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wait_valid", o_tx_valid, 1);
  endtask

  vec_t vt[7];

  initial begin
    int cyc;
    for (int i = 0; i < 4; i++) rom[i] = '0;
    #12;
    chk("rst_valid", o_tx_valid, 0);
    chk("rst_outs", {o_tx_data, o_tx_dc, o_busy, o_done, o_overrun}, 0);
    chk("rst_addr", o_rom_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_tx_ready = 1'b1;
`ifndef ILI_SEQ_LOOP_EN
    vt[0] = '{w: {W(3,0), W(3,0), W(3,0), W(0,8'h01)}, n: 1, b: 36'h001, ovr: 0, cyc: 6};
    vt[1] = '{w: {W(3,0), W(3,0), W(1,8'h48), W(0,8'h36)}, n: 2, b: {18'h0, 9'h148, 9'h036}, ovr: 0, cyc: 9};
    vt[2] = '{w: {W(3,0), W(3,0), W(0,8'h11), W(2,3)}, n: 1, b: 36'h011, ovr: 0, cyc: 38};
    vt[3] = '{w: {W(3,0), W(3,0), W(0,8'h11), W(2,0)}, n: 1, b: 36'h011, ovr: 0, cyc: 8};
    vt[4] = '{w: {W(0,8'hA3), W(0,8'hA2), W(0,8'hA1), W(0,8'hA0)}, n: 4,
              b: {9'h0A3, 9'h0A2, 9'h0A1, 9'h0A0}, ovr: 1, cyc: 13};
    vt[5] = '{w: {W(0,8'h77), W(0,8'h77), W(0,8'h77), W(3,0)}, n: 0, b: 36'h0, ovr: 0, cyc: 3};
    vt[6] = '{w: {W(2,0), W(1,8'hAA), W(2,1), W(1,8'h55)}, n: 2, b: {18'h0, 9'h1AA, 9'h155}, ovr: 1, cyc: 21};

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++) rom[i] = vt[v].w[i*10 +: 10];
      got.delete();
      run(400, cyc);
      chk($sformatf("v%0d_count", v), got.size(), vt[v].n);
      for (int i = 0; i < vt[v].n && i < got.size(); i++)
        chk($sformatf("v%0d_byte%0d", v, i), got[i], vt[v].b[i*9 +: 9]);
      chk($sformatf("v%0d_cycles", v), cyc, vt[v].cyc);
      chk($sformatf("v%0d_overrun", v), o_overrun, vt[v].ovr);
      chk($sformatf("v%0d_busy", v), o_busy, 0);
      if (vt[v].ovr) chk($sformatf("v%0d_nowrap", v), o_rom_addr, 3);
    end

    // Sender stalls for 5 cycles on the first byte.
    rom[0] = W(0, 8'h36); rom[1] = W(1, 8'h48); rom[2] = W(3, 0); rom[3] = W(3, 0);
    got.delete();
    i_tx_ready = 1'b0;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", o_tx_valid, 1);
      chk("stall_byte", {o_tx_dc, o_tx_data}, 9'h036);
      @(posedge clk);
      #1;
    end
    i_tx_ready = 1'b1;
    cyc = 0;
    while (!o_done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("stall_done", o_done, 1);
    exp_q = '{9'h036, 9'h148};
    cmp_bytes("stall_xfer");

    // Reset while SEND waits on ready.
    rom[0] = W(0, 8'h77); rom[1] = W(1, 8'h12); rom[2] = W(3, 0);
    got.delete();
    i_tx_ready = 1'b0;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_valid();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", o_tx_valid, 0);
    chk("arst_outs", {o_tx_data, o_tx_dc, o_busy, o_done, o_overrun}, 0);
    chk("arst_addr", o_rom_addr, 0);
    @(posedge clk);
    #1;
    i_tx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_xfer", got.size(), 0);
    rst = 1'b1;
    run(200, cyc);
    exp_q = '{9'h077, 9'h112};
    cmp_bytes("arst_restart");

    // Randomized tables and ready against the reference walk.
    rnd_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++) begin
        logic [1:0] t;
        t = 2'($urandom_range(0, 3));
        rom[i] = {t, (t == 2'd2) ? 8'($urandom_range(0, 3)) : 8'($urandom)};
      end
      model();
      got.delete();
      run(1000, cyc);
      cmp_bytes($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_overrun", it), o_overrun, exp_ovr);
      chk($sformatf("rnd%0d_busy", it), o_busy, 0);
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    i_tx_ready = 1'b1;
    rom[0] = W(0, 8'h5A); rom[1] = W(2, 1); rom[2] = W(1, 8'hC3); rom[3] = W(3, 0);
    model();
    got.delete();
    run(400, cyc);
    cmp_bytes("model_fixed");
    chk("model_cycles", cyc, exp_cyc);
`else
    // Loop mode: {CMD 01, CMD 2C, END}, restart at address 1.
    begin
      int pulses, last, busy_low, dbl;
      bit prev_done;
      rom[0] = W(0, 8'h01); rom[1] = W(0, 8'h2C); rom[2] = W(3, 0); rom[3] = W(3, 0);
      got.delete();
      pulses = 0; last = 0; busy_low = 0; dbl = 0; prev_done = 1'b0;
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      cyc = 1;
      while (pulses < 10 && cyc < 400) begin
        if (!o_busy) busy_low++;
        if (o_done) begin
          if (prev_done) dbl++;
          if (pulses == 0) chk("loop_first_pass", cyc, 9);
          else             chk("loop_period", cyc - last, 5);
          last = cyc;
          pulses++;
        end
        prev_done = o_done;
        @(posedge clk);
        #1;
        cyc++;
      end
      chk("loop_pulses", pulses, 10);
      chk("loop_busy_low", busy_low, 0);
      chk("loop_done_width", dbl, 0);
      exp_q.delete();
      exp_q.push_back(9'h001);
      for (int i = 0; i < 10; i++) exp_q.push_back(9'h02C);
      cmp_bytes("loop_xfer");
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
